// File: rtl/enc_pkg.sv
// Shared types and constants for the 8-way request encoder.
// Used by req_encoder8 and prio_pick8.
package enc_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam logic [7:0] MERGE_MAX = 8'hFF;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/req_encoder8_prio_pick8.sv
// Combinational 8-way selector: fixed priority (highest index wins), or
// round-robin from start_i when REQ_ENCODER8_RR_ARB_EN is defined.
module prio_pick8
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0] vec_i,
`ifdef REQ_ENCODER8_RR_ARB_EN
  input  logic [IDX_W-1:0] start_i,
`endif
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // select one set bit of vec_i
  always_comb begin
    idx_o   = 3'd0;
    found_o = |vec_i;
`ifdef REQ_ENCODER8_RR_ARB_EN
    // walk backwards so the bit closest to start_i is the last one written
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_o = vec_i[start_i + 3'(k)] ? (start_i + 3'(k)) : idx_o;
    end
`else
    for (int i = 0; i < N_REQ; i++) begin
      idx_o = vec_i[i] ? 3'(i) : idx_o;
    end
`endif
  end

endmodule

// File: rtl/req_encoder8.sv
// Request capture, merge counting and valid/ready grant presentation for
// 8 request lines. Define REQ_ENCODER8_RR_ARB_EN for round-robin arbitration.
module req_encoder8
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enabler,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending,
  output logic [7:0]       merge_cnt
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [7:0]         merge_cnt_q, merge_cnt_d;

  logic               hs_s;
  logic [N_REQ-1:0]   clr_s;
  logic [N_REQ-1:0]   cap_s;
  logic [N_REQ-1:0]   rem_s;
  logic [IDX_W-1:0]   pend_idx_s, rem_idx_s;
  logic               pend_found_s, rem_found_s;

`ifdef REQ_ENCODER8_RR_ARB_EN
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   pend_start_s, rem_start_s;

  // the rem search starts after the index being handed over right now
  assign pend_start_s = last_q + 3'd1;
  assign rem_start_s  = out_idx_q + 3'd1;
`endif

  prio_pick8 u_pick_pend (
    .vec_i   (pending_q),
`ifdef REQ_ENCODER8_RR_ARB_EN
    .start_i (pend_start_s),
`endif
    .idx_o   (pend_idx_s),
    .found_o (pend_found_s)
  );

  prio_pick8 u_pick_rem (
    .vec_i   (rem_s),
`ifdef REQ_ENCODER8_RR_ARB_EN
    .start_i (rem_start_s),
`endif
    .idx_o   (rem_idx_s),
    .found_o (rem_found_s)
  );

  // capture, merge detection and grant sequencing
  always_comb begin
    hs_s      = (state_q == PRESENT) && out_ready;
    clr_s     = hs_s ? onehot8(out_idx_q) : 8'h00;
    cap_s     = enabler ? req : 8'h00;
    pending_d = (pending_q & ~clr_s) | cap_s;
    rem_s     = pending_q & ~onehot8(out_idx_q);
    state_d   = state_q;
    out_idx_d = out_idx_q;
`ifdef REQ_ENCODER8_RR_ARB_EN
    last_d    = hs_s ? out_idx_q : last_q;
`endif

    if (enabler && ((req & pending_q & ~clr_s) != 8'h00) && (merge_cnt_q != MERGE_MAX)) begin
      merge_cnt_d = merge_cnt_q + 8'd1;
    end else begin
      merge_cnt_d = merge_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (pend_found_s) begin
          state_d   = PRESENT;
          out_idx_d = pend_idx_s;
        end else begin
          state_d   = IDLE;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (rem_found_s) begin
            state_d   = PRESENT;
            out_idx_d = rem_idx_s;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d   = IDLE;
        out_idx_d = 3'd0;
      end
    endcase
  end

  // state registers; reset clears everything without waiting for clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_idx_q   <= 3'd0;
      pending_q   <= 8'h00;
      merge_cnt_q <= 8'h00;
`ifdef REQ_ENCODER8_RR_ARB_EN
      last_q      <= 3'd7;
`endif
    end else begin
      state_q     <= state_d;
      out_idx_q   <= out_idx_d;
      pending_q   <= pending_d;
      merge_cnt_q <= merge_cnt_d;
`ifdef REQ_ENCODER8_RR_ARB_EN
      last_q      <= last_d;
`endif
    end
  end

  assign out_valid = (state_q == PRESENT);
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign merge_cnt = merge_cnt_q;

endmodule

// File: tb/tb_req_encoder8.sv
// Directed self-checking bench for req_encoder8 (both arbitration builds).
module tb_req_encoder8;

  logic       clk;
  logic       reset;
  logic       enabler;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic [7:0] merge_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  req_encoder8 dut (
    .clk       (clk),
    .reset     (reset),
    .enabler   (enabler),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .merge_cnt (merge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    enabler   = 1'b1;
    req       = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_idx",   32'(out_idx),   32'd0);
    check("rst_pend",  32'(pending),   32'd0);
    check("rst_merge", 32'(merge_cnt), 32'd0);
    reset = 1'b0;

    // single request, one-edge latency from capture to grant
    req = 8'h01; out_ready = 1'b1;
    step();
    check("s_pend", 32'(pending), 32'h01);
    check("s_valid0", 32'(out_valid), 32'd0);
    req = 8'h00;
    step();
    check("s_valid1", 32'(out_valid), 32'd1);
    check("s_idx", 32'(out_idx), 32'd0);
    step();
    check("s_idle", 32'(out_valid), 32'd0);
    check("s_pend0", 32'(pending), 32'h00);

    // three requests at once, back-to-back grants
    req = 8'hA4;
    step();
    check("a4_pend", 32'(pending), 32'hA4);
    req = 8'h00;
    step();
    check("a4_v1", 32'(out_valid), 32'd1);
`ifdef REQ_ENCODER8_RR_ARB_EN
    check("a4_g1", 32'(out_idx), 32'd2);
    step();
    check("a4_g2", 32'(out_idx), 32'd5);
    step();
    check("a4_g3", 32'(out_idx), 32'd7);
`else
    check("a4_g1", 32'(out_idx), 32'd7);
    step();
    check("a4_g2", 32'(out_idx), 32'd5);
    step();
    check("a4_g3", 32'(out_idx), 32'd2);
`endif
    check("a4_v3", 32'(out_valid), 32'd1);
    step();
    check("a4_end", 32'(out_valid), 32'd0);
    check("a4_pend0", 32'(pending), 32'h00);

    // stall with repeated merges into the presented bit
    out_ready = 1'b0; req = 8'h08;
    step();
    req = 8'h00;
    step();
    check("st_idx", 32'(out_idx), 32'd3);
    req = 8'h08;
    for (int i = 0; i < 5; i++) step();
    check("st_idx_hold", 32'(out_idx), 32'd3);
    check("st_valid", 32'(out_valid), 32'd1);
    check("st_merge", 32'(merge_cnt), 32'd5);
    req = 8'h00; out_ready = 1'b1;
    step();
    check("st_bit3", 32'(pending[3]), 32'd0);
    check("st_idle", 32'(out_valid), 32'd0);

    // enabler low ignores requests
    enabler = 1'b0; req = 8'hFF;
    step();
    step();
    step();
    check("en_pend", 32'(pending), 32'h00);
    check("en_valid", 32'(out_valid), 32'd0);
    check("en_merge", 32'(merge_cnt), 32'd5);
    enabler = 1'b1; req = 8'h00;

    // two-bit collision counts once, then saturation
    out_ready = 1'b0; req = 8'hC0;
    step();
    check("c0_merge0", 32'(merge_cnt), 32'd5);
    step();
`ifdef REQ_ENCODER8_RR_ARB_EN
    check("c0_idx", 32'(out_idx), 32'd6);
`else
    check("c0_idx", 32'(out_idx), 32'd7);
`endif
    check("c0_merge1", 32'(merge_cnt), 32'd6);
    for (int i = 0; i < 300; i++) step();
    check("sat_merge", 32'(merge_cnt), 32'd255);
    req = 8'h00; out_ready = 1'b1;
    step();
`ifdef REQ_ENCODER8_RR_ARB_EN
    check("c0_idx2", 32'(out_idx), 32'd7);
    check("c0_pend", 32'(pending), 32'h80);
`else
    check("c0_idx2", 32'(out_idx), 32'd6);
    check("c0_pend", 32'(pending), 32'h40);
`endif
    step();
    check("c0_idle", 32'(out_valid), 32'd0);
    check("sat_hold", 32'(merge_cnt), 32'd255);

    // asynchronous reset while a grant is presented
    out_ready = 1'b0; req = 8'h30;
    step();
    req = 8'h00;
    step();
    check("ar_valid", 32'(out_valid), 32'd1);
    check("ar_pend", 32'(pending), 32'h30);
    #2 reset = 1'b1;
    #1;
    check("ar_valid0", 32'(out_valid), 32'd0);
    check("ar_pend0", 32'(pending), 32'h00);
    check("ar_idx0", 32'(out_idx), 32'd0);
    check("ar_merge0", 32'(merge_cnt), 32'd0);

    // capture on first edge after release; set wins over clear
    reset = 1'b0; req = 8'h02; out_ready = 1'b1;
    step();
    check("rel_pend", 32'(pending), 32'h02);
    step();
    check("sw_idx", 32'(out_idx), 32'd1);
    check("sw_merge", 32'(merge_cnt), 32'd1);
    step();
    check("sw_pend", 32'(pending), 32'h02);
    check("sw_idle", 32'(out_valid), 32'd0);
    check("sw_merge2", 32'(merge_cnt), 32'd1);
    req = 8'h00;
    step();
    check("sw_regrant", 32'(out_idx), 32'd1);
    step();
    check("sw_done", 32'(pending), 32'h00);

`ifdef REQ_ENCODER8_RR_ARB_EN
    // round-robin alternation between bits 0 and 7
    reset = 1'b1;
    step();
    reset = 1'b0; req = 8'h81; out_ready = 1'b1;
    step();
    step();
    check("rr_g1", 32'(out_idx), 32'd0);
    step();
    check("rr_g2", 32'(out_idx), 32'd7);
    step();
    check("rr_g3", 32'(out_idx), 32'd0);
    req = 8'h00;
    step();
    check("rr_g4", 32'(out_idx), 32'd7);
    step();
    check("rr_end", 32'(out_valid), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
